// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx, uart_tx and uart_rx_fifo.
package uart_pkg;
    localparam int UART_DATA_W = 8;
    typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for uart_rx_fifo: one synchronous write port, one async read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter  int DATA_W = UART_DATA_W,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are not reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte queue between UART receiver and transmitter.
// Define UART_RX_FIFO_STATS_EN to add drop_count and max_count outputs.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W = UART_DATA_W,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
`ifdef UART_RX_FIFO_STATS_EN
    output logic [7:0]        drop_count,
    output logic [ADDR_W:0]   max_count,
`endif
    input  logic              clr_overflow
);

    localparam logic [ADDR_W:0] PTR_ONE  = 1;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    logic            push, pop, drop;

    // The extra pointer MSB separates full from empty.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (count == FULL_CNT);
    assign rd_valid = !empty;
    assign overflow = overflow_q;

    assign pop  = rd_valid && rd_ready;
    assign push = wr_valid && (!full || pop);
    assign drop = wr_valid && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_RX_FIFO_STATS_EN
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic [ADDR_W:0] max_cnt_q, max_cnt_d;
    logic [ADDR_W:0] count_d;

    assign count_d    = wr_ptr_d - rd_ptr_d;
    assign drop_count = drop_cnt_q;
    assign max_count  = max_cnt_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        max_cnt_d  = max_cnt_q;
        if (drop) begin
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (clr_overflow) begin
            drop_cnt_d = '0;
        end
        if (clr_overflow) begin
            max_cnt_d = '0;
        end else if (count_d > max_cnt_q) begin
            max_cnt_d = count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            max_cnt_q  <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            max_cnt_q  <= max_cnt_d;
        end
    end
`endif

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (rd_data)
    );

endmodule
